psy5_video_sync_irq: RTL

- Sits directly downstream of the video timing generator (VTG).
- Consumes the VTG's absolute 9-bit H/V pixel counters.
- Produces registered blanking, sync, visible-area and frame-start strobes for the video output stage.
- Also produces the two Z80 main-CPU interrupt requests (mid-frame RST 08h, vblank RST 10h), with IM0 vector supply and acknowledge handshake.

---
 rtl/psy5_video_sync_irq_pkg.sv | 31 +++
 rtl/psy5_video_sync_irq_if.sv | 12 +
 rtl/psy5_video_sync_irq_irq_ctrl.sv | 68 ++++++
 rtl/psy5_video_sync_irq.sv | 75 +++++++
 4 files changed

// File: rtl/psy5_video_sync_irq_pkg.sv
// Shared timing constants, IM0 vectors and IRQ state type for the PSY5 video
// sync / interrupt block.
package psy5_video_pkg;

   localparam logic [8:0] HBL_END      = 9'd256;
   localparam logic [8:0] HS_START     = 9'd176;
   localparam logic [8:0] HS_END       = 9'd207;
   localparam logic [8:0] VBL_START    = 9'd496;
   localparam logic [8:0] VBL_END      = 9'd272;
   localparam logic [8:0] VS_START     = 9'd232;
   localparam logic [8:0] VS_END       = 9'd239;
   localparam logic [8:0] IRQ_MID_LINE = 9'd376;
   localparam logic [8:0] IRQ_VBL_LINE = 9'd496;
   localparam logic [8:0] H_LAST       = 9'd511;

   localparam logic [7:0] IVEC_RST08 = 8'hCF;
   localparam logic [7:0] IVEC_RST10 = 8'hD7;
   localparam logic [7:0] IVEC_NONE  = 8'hFF;

   typedef enum logic {
      IRQ_IDLE = 1'b0,
      IRQ_PEND = 1'b1
   } irq_st_t;

   // Inclusive window test; compare-only so the counters never feed an adder.
   function automatic logic in_win(input logic [8:0] v, input logic [8:0] lo,
                                   input logic [8:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/psy5_video_sync_irq_if.sv
// Z80 interrupt-acknowledge bus between the main CPU and the video IRQ block.
interface psy5_video_sync_irq_if;
   logic       i_Z80_M1_n;
   logic       i_Z80_IORQ_n;
   logic       o_Z80_INT_n;
   logic [7:0] o_Z80_IVEC;

   modport master (output i_Z80_M1_n, output i_Z80_IORQ_n,
                   input  o_Z80_INT_n, input o_Z80_IVEC);
   modport slave  (input  i_Z80_M1_n, input i_Z80_IORQ_n,
                   output o_Z80_INT_n, output o_Z80_IVEC);
endinterface

// File: rtl/psy5_video_sync_irq_irq_ctrl.sv
// Two-source Z80 IRQ controller: pending flags, IM0 acknowledge edge detect,
// vblank-over-mid priority and latched vector byte.
module psy5_irq_ctrl
   import psy5_video_pkg::*;
(
   input  logic       i_EMU_MCLK,
   input  logic       i_EMU_INITRST_n,
   input  logic       irq_en,
   input  logic       set_mid,
   input  logic       set_vbl,
   input  logic       z80_m1_n,
   input  logic       z80_iorq_n,
   output logic       z80_int_n,
   output logic [7:0] z80_ivec
);

   irq_st_t    mid_q, mid_d, vbl_q, vbl_d;
   logic       ack_q, ack_lvl, ack_edge;
   logic [7:0] ivec_q, ivec_d;

   assign ack_lvl  = ~z80_m1_n & ~z80_iorq_n;
   assign ack_edge = ack_lvl & ~ack_q;

   always_ff @(posedge i_EMU_MCLK) begin
      if (!i_EMU_INITRST_n) begin
         mid_q  <= IRQ_IDLE;
         vbl_q  <= IRQ_IDLE;
         ack_q  <= 1'b0;
         ivec_q <= IVEC_NONE;
      end else begin
         mid_q  <= mid_d;
         vbl_q  <= vbl_d;
         ack_q  <= ack_lvl;
         ivec_q <= ivec_d;
      end
   end

   // Acknowledge clears the served flag first, then a same-cycle set re-arms it,
   // so a request arriving during service is never dropped.
   always_comb begin
      mid_d  = mid_q;
      vbl_d  = vbl_q;
      ivec_d = ivec_q;
      if (ack_edge) begin
         if (vbl_q == IRQ_PEND) begin
            ivec_d = IVEC_RST10;
            vbl_d  = IRQ_IDLE;
         end else if (mid_q == IRQ_PEND) begin
            ivec_d = IVEC_RST08;
            mid_d  = IRQ_IDLE;
         end else begin
            ivec_d = IVEC_NONE;
         end
      end
      if (set_mid) mid_d = IRQ_PEND;
      if (set_vbl) vbl_d = IRQ_PEND;
      if (!irq_en) begin
         mid_d = IRQ_IDLE;
         vbl_d = IRQ_IDLE;
      end
   end

   always_comb begin
      z80_int_n = ~((mid_q == IRQ_PEND) | (vbl_q == IRQ_PEND));
      z80_ivec  = ivec_q;
   end

endmodule

// File: rtl/psy5_video_sync_irq.sv
// Registered blank/sync/visible/frame-start decode of the VTG counters plus
// the Z80 mid-frame and vblank interrupt sources.
module psy5_video_sync_irq
   import psy5_video_pkg::*;
#(
   parameter logic [8:0] P_HBL_END      = HBL_END,
   parameter logic [8:0] P_HS_START     = HS_START,
   parameter logic [8:0] P_HS_END       = HS_END,
   parameter logic [8:0] P_VBL_START    = VBL_START,
   parameter logic [8:0] P_VBL_END      = VBL_END,
   parameter logic [8:0] P_VS_START     = VS_START,
   parameter logic [8:0] P_VS_END       = VS_END,
   parameter logic [8:0] P_IRQ_MID_LINE = IRQ_MID_LINE,
   parameter logic [8:0] P_IRQ_VBL_LINE = IRQ_VBL_LINE
)(
   input  logic                  i_EMU_MCLK,
   input  logic                  i_EMU_INITRST_n,
   input  logic                  i_EMU_CLK6MPCEN_n,
   input  logic [8:0]            i_ABS_H_CNTR,
   input  logic [8:0]            i_ABS_V_CNTR,
   input  logic                  i_IRQ_EN,
   psy5_video_sync_irq_if.slave  z80,
   output logic                  o_HBLANK_n,
   output logic                  o_VBLANK_n,
   output logic                  o_HSYNC_n,
   output logic                  o_VSYNC_n,
   output logic                  o_VIDEO_EN,
   output logic                  o_FRAME_START
);

   logic ce, hbl, vbl, hs, vs, fs, line_end, set_mid, set_vbl;

   assign ce  = ~i_EMU_CLK6MPCEN_n;
   assign hbl = i_ABS_H_CNTR < P_HBL_END;
   // Vertical blank wraps through the counter top, hence the OR of two compares.
   assign vbl = (i_ABS_V_CNTR >= P_VBL_START) | (i_ABS_V_CNTR < P_VBL_END);
   assign hs  = in_win(i_ABS_H_CNTR, P_HS_START, P_HS_END);
   assign vs  = in_win(i_ABS_V_CNTR, P_VS_START, P_VS_END);
   assign fs  = (i_ABS_V_CNTR == P_VBL_END) & (i_ABS_H_CNTR == P_HBL_END);

   assign line_end = ce & (i_ABS_H_CNTR == H_LAST);
   assign set_mid  = line_end & (i_ABS_V_CNTR == P_IRQ_MID_LINE);
   assign set_vbl  = line_end & (i_ABS_V_CNTR == P_IRQ_VBL_LINE);

   always_ff @(posedge i_EMU_MCLK) begin
      if (!i_EMU_INITRST_n) begin
         o_HBLANK_n    <= 1'b0;
         o_VBLANK_n    <= 1'b0;
         o_HSYNC_n     <= 1'b1;
         o_VSYNC_n     <= 1'b1;
         o_VIDEO_EN    <= 1'b0;
         o_FRAME_START <= 1'b0;
      end else if (ce) begin
         o_HBLANK_n    <= ~hbl;
         o_VBLANK_n    <= ~vbl;
         o_HSYNC_n     <= ~hs;
         o_VSYNC_n     <= ~vs;
         o_VIDEO_EN    <= ~hbl & ~vbl;
         o_FRAME_START <= fs;
      end
   end

   psy5_irq_ctrl u_irq (
      .i_EMU_MCLK      (i_EMU_MCLK),
      .i_EMU_INITRST_n (i_EMU_INITRST_n),
      .irq_en          (i_IRQ_EN),
      .set_mid         (set_mid),
      .set_vbl         (set_vbl),
      .z80_m1_n        (z80.i_Z80_M1_n),
      .z80_iorq_n      (z80.i_Z80_IORQ_n),
      .z80_int_n       (z80.o_Z80_INT_n),
      .z80_ivec        (z80.o_Z80_IVEC)
   );

endmodule
